run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 193 +++++++++++++++++++
 tb/tb_run_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Run sequencer for a DUT test harness: holds the harness in reset, enables
// stimulus for a programmed number of cycles, lets in-flight results drain,
// then snapshots the harness counters into result registers.
//
// state   | meaning
// IDLE    | harness held in reset, waiting for a run request
// CLEAR   | harness held in reset for CLEAR_CYCLES before stimulus
// RUN     | stimulus enabled, one cycle per programmed run length
// DRAIN   | stimulus stopped, counters still live for in-flight results
// CAPTURE | harness frozen for two cycles, counters sampled at the end
// DONE    | results held until the next run request
module run_controller #(
   parameter int CTR_WIDTH    = 32,
   parameter int CLEAR_CYCLES = 2,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic                 clk_dut,
   input  logic                 reset,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [CTR_WIDTH-1:0] i_run_len,
   output logic                 o_tb_reset,
   output logic                 o_tb_enable,
   output logic                 o_tb_freeze,
   input  logic [CTR_WIDTH-1:0] i_data_ctr,
   input  logic [CTR_WIDTH-1:0] i_event_ctr,
   input  logic [CTR_WIDTH-1:0] i_dut_delay,
   output logic [CTR_WIDTH-1:0] o_res_data,
   output logic [CTR_WIDTH-1:0] o_res_event,
   output logic [CTR_WIDTH-1:0] o_res_delay,
   output logic [CTR_WIDTH-1:0] o_cycles_run,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_aborted,
   output logic [2:0]           o_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      RUN     = 3'd2,
      DRAIN   = 3'd3,
      CAPTURE = 3'd4,
      DONE    = 3'd5
   } state_t;

   // Timer loads are "cycles - 1" because the terminal count is reached on
   // the last cycle spent in the state.
   localparam logic [CTR_WIDTH-1:0] CLR_LOAD = CTR_WIDTH'(CLEAR_CYCLES - 1);
   localparam logic [CTR_WIDTH-1:0] DRN_LOAD = CTR_WIDTH'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
   localparam logic [CTR_WIDTH-1:0] CAP_LOAD = CTR_WIDTH'(1);
   localparam logic [CTR_WIDTH-1:0] ONE      = CTR_WIDTH'(1);

   state_t               state_q, state_d;
   logic [CTR_WIDTH-1:0] tmr_q, tmr_d;
   logic [CTR_WIDTH-1:0] len_q, len_d;
   logic [CTR_WIDTH-1:0] cycles_q, cycles_d;
   logic [CTR_WIDTH-1:0] res_data_q, res_data_d;
   logic [CTR_WIDTH-1:0] res_event_q, res_event_d;
   logic [CTR_WIDTH-1:0] res_delay_q, res_delay_d;
   logic                 aborted_q, aborted_d;
   logic [CTR_WIDTH-1:0] tmr_dec;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_dut) begin
      if (reset) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         len_q       <= '0;
         cycles_q    <= '0;
         res_data_q  <= '0;
         res_event_q <= '0;
         res_delay_q <= '0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         len_q       <= len_d;
         cycles_q    <= cycles_d;
         res_data_q  <= res_data_d;
         res_event_q <= res_event_d;
         res_delay_q <= res_delay_d;
         aborted_q   <= aborted_d;
      end
   end

   // Next-state, timer and result update logic.
   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      len_d       = len_q;
      cycles_d    = cycles_q;
      res_data_d  = res_data_q;
      res_event_d = res_event_q;
      res_delay_d = res_delay_q;
      aborted_d   = aborted_q;
      tmr_dec     = (tmr_q == '0) ? '0 : tmr_q - ONE;

      case (state_q)
         IDLE, DONE: begin
            if (i_start) begin
               len_d       = i_run_len;
               cycles_d    = '0;
               res_data_d  = '0;
               res_event_d = '0;
               res_delay_d = '0;
               aborted_d   = 1'b0;
               if (i_run_len == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = CLEAR;
                  tmr_d   = CLR_LOAD;
               end
            end
         end
         CLEAR: begin
            if (i_abort) begin
               state_d   = CAPTURE;
               tmr_d     = CAP_LOAD;
               aborted_d = 1'b1;
            end else if (tmr_q == '0) begin
               state_d = RUN;
               tmr_d   = (len_q == '0) ? '0 : len_q - ONE;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         RUN: begin
            // The cycle carrying an abort still had stimulus enabled, so it counts.
            cycles_d = (&cycles_q) ? cycles_q : cycles_q + ONE;
            if (i_abort) begin
               state_d   = CAPTURE;
               tmr_d     = CAP_LOAD;
               aborted_d = 1'b1;
            end else if (tmr_q == '0) begin
               if (DRAIN_CYCLES == 0) begin
                  state_d = CAPTURE;
                  tmr_d   = CAP_LOAD;
               end else begin
                  state_d = DRAIN;
                  tmr_d   = DRN_LOAD;
               end
            end else begin
               tmr_d = tmr_dec;
            end
         end
         DRAIN: begin
            if (i_abort) begin
               state_d   = CAPTURE;
               tmr_d     = CAP_LOAD;
               aborted_d = 1'b1;
            end else if (tmr_q == '0) begin
               state_d = CAPTURE;
               tmr_d   = CAP_LOAD;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         CAPTURE: begin
            if (tmr_q == '0) begin
               res_data_d  = i_data_ctr;
               res_event_d = i_event_ctr;
               res_delay_d = i_dut_delay;
               state_d     = DONE;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         default: begin
            state_d = IDLE;
            tmr_d   = '0;
         end
      endcase
   end

   // Moore output decode from the registered state.
   always_comb begin
      o_tb_reset  = (state_q == IDLE) || (state_q == CLEAR);
      o_tb_enable = (state_q == RUN);
      o_tb_freeze = !((state_q == RUN) || (state_q == DRAIN));
      o_busy      = (state_q == CLEAR) || (state_q == RUN) ||
                    (state_q == DRAIN) || (state_q == CAPTURE);
      o_done      = (state_q == DONE);
   end

   assign o_state      = state_q;
   assign o_cycles_run = cycles_q;
   assign o_res_data   = res_data_q;
   assign o_res_event  = res_event_q;
   assign o_res_delay  = res_delay_q;
   assign o_aborted    = aborted_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller with hand-computed expectations.
module tb_run_controller;

   logic        clk_dut = 1'b0;
   logic        reset;
   logic        i_start;
   logic        i_abort;
   logic [31:0] i_run_len;
   logic        o_tb_reset, o_tb_enable, o_tb_freeze;
   logic [31:0] i_data_ctr, i_event_ctr, i_dut_delay;
   logic [31:0] o_res_data, o_res_event, o_res_delay, o_cycles_run;
   logic        o_busy, o_done, o_aborted;
   logic [2:0]  o_state;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk_dut = ~clk_dut;

   run_controller dut (
      .clk_dut      (clk_dut),
      .reset        (reset),
      .i_start      (i_start),
      .i_abort      (i_abort),
      .i_run_len    (i_run_len),
      .o_tb_reset   (o_tb_reset),
      .o_tb_enable  (o_tb_enable),
      .o_tb_freeze  (o_tb_freeze),
      .i_data_ctr   (i_data_ctr),
      .i_event_ctr  (i_event_ctr),
      .i_dut_delay  (i_dut_delay),
      .o_res_data   (o_res_data),
      .o_res_event  (o_res_event),
      .o_res_delay  (o_res_delay),
      .o_cycles_run (o_cycles_run),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_aborted    (o_aborted),
      .o_state      (o_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk_dut);
      #1;
   endtask

   task automatic start_run(input logic [31:0] len);
      i_run_len = len;
      i_start   = 1'b1;
      tick();
      i_start   = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!o_done && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(o_done), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"},  32'(o_state), 32'd0);
      check({tag, "_tbrst"},  32'(o_tb_reset), 32'd1);
      check({tag, "_en"},     32'(o_tb_enable), 32'd0);
      check({tag, "_frz"},    32'(o_tb_freeze), 32'd1);
      check({tag, "_busy"},   32'(o_busy), 32'd0);
      check({tag, "_done"},   32'(o_done), 32'd0);
      check({tag, "_abt"},    32'(o_aborted), 32'd0);
      check({tag, "_cyc"},    o_cycles_run, 32'd0);
      check({tag, "_rdata"},  o_res_data, 32'd0);
      check({tag, "_revent"}, o_res_event, 32'd0);
      check({tag, "_rdelay"}, o_res_delay, 32'd0);
   endtask

   logic [2:0] st_log [1:19];
   logic       dn_log [1:19];
   int         en_cnt;

   initial begin
      reset       = 1'b1;
      i_start     = 1'b0;
      i_abort     = 1'b0;
      i_run_len   = 32'd0;
      i_data_ctr  = 32'h0000_1111;
      i_event_ctr = 32'h0000_2222;
      i_dut_delay = 32'h0000_3333;
      tick();
      tick();
      reset = 1'b0;
      check_reset_outputs("rst");

      // Normal run of 10: CLEAR 1-2, RUN 3-12, DRAIN 13-16, CAPTURE 17-18, DONE 19.
      start_run(32'd10);
      en_cnt = 0;
      for (int c = 1; c <= 19; c++) begin
         st_log[c] = o_state;
         dn_log[c] = o_done;
         if (o_tb_enable) en_cnt++;
         if (c < 19) tick();
      end
      check("n_c1_clear",  32'(st_log[1]),  32'd1);
      check("n_c2_clear",  32'(st_log[2]),  32'd1);
      check("n_c3_run",    32'(st_log[3]),  32'd2);
      check("n_c12_run",   32'(st_log[12]), 32'd2);
      check("n_c13_drain", 32'(st_log[13]), 32'd3);
      check("n_c16_drain", 32'(st_log[16]), 32'd3);
      check("n_c17_cap",   32'(st_log[17]), 32'd4);
      check("n_c18_cap",   32'(st_log[18]), 32'd4);
      check("n_c18_ndone", 32'(dn_log[18]), 32'd0);
      check("n_c19_done",  32'(dn_log[19]), 32'd1);
      check("n_en_count",  32'(en_cnt), 32'd10);
      check("n_cycles",    o_cycles_run, 32'd10);
      check("n_rdata",     o_res_data,  32'h0000_1111);
      check("n_revent",    o_res_event, 32'h0000_2222);
      check("n_rdelay",    o_res_delay, 32'h0000_3333);
      check("n_abt",       32'(o_aborted), 32'd0);
      check("n_frz_done",  32'(o_tb_freeze), 32'd1);
      tick();
      tick();
      check("n_hold_done", 32'(o_done), 32'd1);
      check("n_hold_cyc",  o_cycles_run, 32'd10);

      // Abort on the 5th RUN cycle of a 100-cycle run; counters change during CAPTURE.
      start_run(32'd100);
      tick();
      tick();
      tick();
      tick();
      tick();
      tick();
      check("a_c7_run",   32'(o_state), 32'd2);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check("a_cap",      32'(o_state), 32'd4);
      check("a_abt",      32'(o_aborted), 32'd1);
      check("a_cycles",   o_cycles_run, 32'd5);
      check("a_en_off",   32'(o_tb_enable), 32'd0);
      i_data_ctr  = 32'h0000_AAAA;
      i_event_ctr = 32'h0000_BBBB;
      i_dut_delay = 32'h0000_00CC;
      tick();
      check("a_cap2",     32'(o_state), 32'd4);
      check("a_rdata_pre", o_res_data, 32'd0);
      tick();
      check("a_done",     32'(o_done), 32'd1);
      check("a_rdata",    o_res_data,  32'h0000_AAAA);
      check("a_revent",   o_res_event, 32'h0000_BBBB);
      check("a_rdelay",   o_res_delay, 32'h0000_00CC);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check("a_ign_done", 32'(o_state), 32'd5);

      // Zero-length run from DONE goes straight back to DONE with cleared results.
      start_run(32'd0);
      check("z_done",   32'(o_state), 32'd5);
      check("z_en",     32'(o_tb_enable), 32'd0);
      check("z_cycles", o_cycles_run, 32'd0);
      check("z_rdata",  o_res_data, 32'd0);
      check("z_abt",    32'(o_aborted), 32'd0);

      // Reset mid-run with a simultaneous start: reset wins.
      start_run(32'd50);
      repeat (4) tick();
      check("r_in_run", 32'(o_state), 32'd2);
      reset   = 1'b1;
      i_start = 1'b1;
      i_abort = 1'b1;
      tick();
      reset   = 1'b0;
      i_start = 1'b0;
      i_abort = 1'b0;
      check_reset_outputs("mrst");
      start_run(32'd3);
      check("r3_clear", 32'(o_state), 32'd1);
      wait_done("r3_wait", 40);
      check("r3_cycles", o_cycles_run, 32'd3);
      check("r3_abt",    32'(o_aborted), 32'd0);

      // Start while busy is ignored; start from DONE clears and re-runs.
      start_run(32'd5);
      repeat (3) tick();
      i_run_len = 32'd99;
      i_start   = 1'b1;
      tick();
      i_start   = 1'b0;
      check("b_still_run", 32'(o_state), 32'd2);
      wait_done("b_wait", 40);
      check("b_cycles", o_cycles_run, 32'd5);
      start_run(32'd2);
      check("b_restart", 32'(o_state), 32'd1);
      check("b_clr_cyc", o_cycles_run, 32'd0);
      check("b_clr_res", o_res_data, 32'd0);
      wait_done("b2_wait", 40);
      check("b2_cycles", o_cycles_run, 32'd2);

      // Start+abort in IDLE starts a run; start+abort in RUN takes the abort.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      i_run_len = 32'd20;
      i_start   = 1'b1;
      i_abort   = 1'b1;
      tick();
      i_start   = 1'b0;
      i_abort   = 1'b0;
      check("sa_idle_clear", 32'(o_state), 32'd1);
      check("sa_idle_abt",   32'(o_aborted), 32'd0);
      tick();
      tick();
      tick();
      check("sa_run", 32'(o_state), 32'd2);
      i_start = 1'b1;
      i_abort = 1'b1;
      tick();
      i_start = 1'b0;
      i_abort = 1'b0;
      check("sa_run_cap", 32'(o_state), 32'd4);
      check("sa_run_abt", 32'(o_aborted), 32'd1);
      check("sa_run_cyc", o_cycles_run, 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
